// File: rtl/div_restoring.sv
// div_restoring
// ---------------------------------------------------------------------------
// Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU.
// Quotient and remainder come out together after 34 cycles of go=1. The LOAD
// cycle is cycle 0, ITER1..ITER32 are cycles 1..32 and FINISH is cycle 33.
// The unit returns the RISC-V results for divide-by-zero and for signed
// overflow and never traps.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   go         in   request, held by the requester until done
//   sign       in   1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   n          in   [31:0] dividend, sampled in the LOAD cycle only
//   d          in   [31:0] divisor, sampled in the LOAD cycle only
//   done       out  one-cycle pulse, high when quotient/remainder are valid
//   quotient   out  [31:0] quotient, truncated toward zero
//   remainder  out  [31:0] remainder, takes the sign of the dividend
//
// Configuration macro: DIV_FASTPATH_EN
//   When defined, the LOAD cycle detects divide-by-zero and signed overflow.
//   It loads the final result directly and jumps to FINISH, so done asserts
//   in cycle 1.
// ---------------------------------------------------------------------------
module div_restoring (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        sign,
  input  logic [31:0] n,
  input  logic [31:0] d,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  // One-hot sequencer phases.
  localparam logic [33:0] ST_LOAD   = 34'h0_0000_0001;
  localparam logic [33:0] ST_ITER1  = 34'h0_0000_0002;
  localparam logic [33:0] ST_FINISH = 34'h2_0000_0000;

  // Magnitude of a 32-bit operand. The most negative value maps onto itself,
  // which is the correct unsigned magnitude 0x80000000.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic s);
    if (s & v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

  logic [33:0] r_state;
  logic [31:0] r_q;      // dividend being shifted out / quotient shifted in
  logic [31:0] r_d;      // divisor magnitude
  // Partial remainder. It always stays below the divisor, so its top bit
  // would never be set. It is therefore held as 32 bits.
  logic [31:0] r_p;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [32:0] w_trial;
  logic        w_neg_q;
  logic        w_neg_r;
  logic        w_iter;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign w_trial = {r_p, r_q[31]} - {1'b0, r_d};
  // A zero divisor must not negate the all-ones quotient.
  assign w_neg_q = sign & (n[31] ^ d[31]) & (d != 32'd0);
  assign w_neg_r = sign & n[31];
  assign w_iter  = |r_state[32:1];

`ifdef DIV_FASTPATH_EN
  logic w_div_zero;
  logic w_ovf;
  assign w_div_zero = (d == 32'd0);
  assign w_ovf      = sign & (n == 32'h8000_0000) & (d == 32'hFFFF_FFFF);
`endif

  // Sequencer plus datapath registers: load, iterate, finish, abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_LOAD;
      r_q     <= 32'd0;
      r_d     <= 32'd0;
      r_p     <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state[0]) begin
      if (go) begin
`ifdef DIV_FASTPATH_EN
        if (w_div_zero) begin
          r_q     <= 32'hFFFF_FFFF;
          r_p     <= n;
          r_d     <= 32'd0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
          r_state <= ST_FINISH;
        end else if (w_ovf) begin
          r_q     <= 32'h8000_0000;
          r_p     <= 32'd0;
          r_d     <= 32'd0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
          r_state <= ST_FINISH;
        end else begin
          r_q     <= abs32(n, sign);
          r_d     <= abs32(d, sign);
          r_p     <= 32'd0;
          r_neg_q <= w_neg_q;
          r_neg_r <= w_neg_r;
          r_state <= ST_ITER1;
        end
`else
        r_q     <= abs32(n, sign);
        r_d     <= abs32(d, sign);
        r_p     <= 32'd0;
        r_neg_q <= w_neg_q;
        r_neg_r <= w_neg_r;
        r_state <= ST_ITER1;
`endif
      end else begin
        r_state <= ST_LOAD;
      end
    end else if (!go) begin
      // The requester abandoned the operation.
      r_state <= ST_LOAD;
    end else if (r_state[33]) begin
      r_state <= ST_LOAD;
    end else if (w_iter) begin
      if (!w_trial[32]) begin
        r_p <= w_trial[31:0];
        r_q <= {r_q[30:0], 1'b1};
      end else begin
        r_p <= {r_p[30:0], r_q[31]};
        r_q <= {r_q[30:0], 1'b0};
      end
      r_state <= {r_state[32:0], 1'b0};
    end else begin
      // A corrupted (non one-hot) state recovers to LOAD.
      r_state <= ST_LOAD;
    end
  end

  // Result sign correction. It is combinational from the registers.
  always_comb begin
    done      = r_state[33] & go;
    quotient  = r_q;
    remainder = r_p;
    if (r_neg_q) begin
      quotient = 32'd0 - r_q;
    end else begin
      quotient = r_q;
    end
    if (r_neg_r) begin
      remainder = 32'd0 - r_p;
    end else begin
      remainder = r_p;
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// tb_div_restoring
// ---------------------------------------------------------------------------
// Directed bench for div_restoring. Inputs change on the falling edge, and
// outputs are sampled 1 ns after that edge. Each request reports the cycle in
// which done appeared, counted from its LOAD cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_div_restoring;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] n = 32'd0;
  logic [31:0] d = 32'd0;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;

`ifdef DIV_FASTPATH_EN
  localparam int ZCYC = 1;
`else
  localparam int ZCYC = 33;
`endif

  always #5 clk = ~clk;

  div_restoring dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .sign      (sign),
    .n         (n),
    .d         (d),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start a request at a falling edge and wait (bounded) for done.
  // Then check latency, results and the single-cycle done pulse.
  // With hold=1, go stays high, so the next cycle is the next LOAD.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int exp_cyc, input logic [31:0] eq,
                        input logic [31:0] er, input bit hold);
    int cyc;
    bit seen;
    go = 1'b1; n = a; d = b; sign = s;
    cyc = 0; seen = 1'b0;
    while (cyc < 100 && !seen) begin
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    @(negedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    if (!hold) begin
      go = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    bit any_done;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Main function across sign combinations.
    run_op("u100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("s-7_-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 33, 32'd3, 32'hFFFF_FFFF, 1'b0);
    run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Divide by zero.
    run_op("s-5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, ZCYC, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
    run_op("u5_0", 32'd5, 32'd0, 1'b0, ZCYC, 32'hFFFF_FFFF, 32'd5, 1'b0);

    // Signed overflow, and the same operands unsigned.
    run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, ZCYC, 32'h8000_0000, 32'd0, 1'b0);
    run_op("uovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 32'd0, 32'h8000_0000, 1'b0);

    // Abort: drop go in cycle 10 of 1000/3, then run 9/4.
    any_done = 1'b0;
    go = 1'b1; n = 32'd1000; d = 32'd3; sign = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (done !== 1'b0) any_done = 1'b1;
      @(negedge clk);
    end
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done !== 1'b0) any_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_nodone", {31'd0, any_done}, 32'd0);
    run_op("u9_4", 32'd9, 32'd4, 1'b0, 33, 32'd2, 32'd1, 1'b0);

    // Back-to-back: done in cycles 33 and 67 of a continuous go.
    run_op("b2b_50", 32'd50, 32'd5, 1'b0, 33, 32'd10, 32'd0, 1'b1);
    run_op("b2b_51", 32'd51, 32'd5, 1'b0, 33, 32'd10, 32'd1, 1'b0);

    // Reset in cycle 20 of an operation, then a fresh 1000/3.
    go = 1'b1; n = 32'd1000; d = 32'd3; sign = 1'b0;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    go = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("u1000_3", 32'd1000, 32'd3, 1'b0, 33, 32'd333, 32'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_restoring.md
# div_restoring

Iterative 32-bit restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It produces quotient and remainder together. It sits beside the Booth multiplier in the execute stage and uses the same handshake: the execute stage holds `go` until `done`. It returns RISC-V-defined results for divide-by-zero and signed overflow without trapping.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: reset; synchronous and active-low.
- `go` input 1: request; held high by the requester until `done`.
- `sign` input 1: 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); applies to both operands.
- `n` input 32: dividend; sampled only in the load cycle.
- `d` input 32: divisor; sampled only in the load cycle.
- `done` output 1: high for exactly one cycle when `quotient` and `remainder` are valid.
- `quotient` output 32: quotient, truncated toward zero.
- `remainder` output 32: remainder; takes the sign of the dividend.

## Operation
- One-hot sequencer `state[33:0]`, with phases LOAD (bit 0), ITER1..ITER32 (bits 1..32) and FINISH (bit 33).
  - Reset value is `34'b1` (LOAD).
  - The sequencer advances one bit per cycle only while `go`=1.
- LOAD (cycle with `state[0]` and `go`):
  - Latch `neg_q = sign & (n[31]^d[31]) & (d!=0)` and `neg_r = sign & n[31]`.
  - Latch `|n|` into quotient register Q[31:0] and `|d|` into divisor register D[31:0]. The absolute value is the two's-complement negate when `sign` and the MSB are set; `|0x80000000|` = `0x80000000` unsigned.
  - Clear partial remainder P[32:0].
- ITERk:
  - T = {P[31:0],Q[31]} − {1'b0,D}, computed 33 bits wide.
  - If T[32]=0: P←T, Q←{Q[30:0],1}.
  - Else: P←{P[31:0],Q[31]}, Q←{Q[30:0],0}.
- FINISH:
  - `done`=`go`.
  - `quotient` = neg_q ? −Q : Q.
  - `remainder` = neg_r ? −P[31:0] : P[31:0].
  - Both are combinational from the registers.
  - Next state is LOAD.
- Divide-by-zero with no special path:
  - The iteration yields Q=all ones and P=|n|.
  - The `d!=0` term suppresses quotient negation, giving q=`0xFFFFFFFF` and r=n.
- Signed overflow (`0x80000000`/`0xFFFFFFFF`): q=`0x80000000`, r=0.
- Abort: `go`=0 in any non-LOAD state returns the sequencer to LOAD on the next edge. No `done` is generated, and operands are resampled at the next LOAD.
- `reset_n`=0 in any state: sequencer to LOAD and Q/P/D/flags to 0 on the next edge.

## Timing
- Reset values:
  - `done`=0.
  - `quotient`=0, `remainder`=0 (registers cleared, negate flags 0).
- Latency: `done` asserts in the 34th consecutive cycle of `go`=1, counting the LOAD cycle as cycle 0, so FINISH is cycle 33.
- The requester deasserts `go` in the cycle after `done`.
- If `go` stays high after `done`, the next cycle is a new LOAD with the current `n`/`d`/`sign` (back-to-back, no bubble).
- `quotient`/`remainder` are valid only while `done`=1; at other times their values are unspecified.
- `n`, `d` and `sign` may change freely outside the LOAD cycle.

## Configuration
- `DIV_FASTPATH_EN` defined:
  - In LOAD, detect `d==0`, or `sign & n==0x80000000 & d==0xFFFFFFFF`.
  - Load the final Q/P directly and jump to FINISH, so `done` asserts in cycle 1.
  - Divide-by-zero loads Q=`0xFFFFFFFF`, P=n with both negate flags forced 0.
  - Overflow loads Q=`0x80000000`, P=0 with both negate flags forced 0.
  - All other operand pairs take 34 cycles.
- `DIV_FASTPATH_EN` undefined: every operation takes 34 cycles. Special-case results come from the iteration as described under Operation.

## Test plan
- Unsigned 100/7, `go` held → `done` in cycle 33 only, q=14, r=2. Signed, n=−7 (`0xFFFFFFF9`), d=2 → q=`0xFFFFFFFD`, r=`0xFFFFFFFF`.
- Signed −5/0 and unsigned 5/0 → q=`0xFFFFFFFF`, r=`0xFFFFFFFB` and r=5 respectively. `done` in cycle 1 with the macro, cycle 33 without.
- Signed `0x80000000`/`0xFFFFFFFF` → q=`0x80000000`, r=0. The same operands unsigned → q=0, r=`0x80000000`, always in cycle 33.
- Abort: unsigned 1000/3, drop `go` in cycle 10, re-assert with unsigned 9/4 → no `done` for the first request. `done` arrives 33 cycles after the new LOAD with q=2, r=1.
- Back-to-back: unsigned 50/5 then 51/5 with `go` held → `done` in cycles 33 and 67, giving (10,0) then (10,1).
- Assert `reset_n`=0 in cycle 20, release, then run unsigned 1000/3 → `done`/q/r are 0 during reset. The new operation gives q=333, r=1 at cycle 33 after release.
